// File: rtl/xgriscv_mem_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory arbiter.
package xgriscv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_MEM_LAT    = 2;
  localparam int unsigned ARB_STARVE_MAX = 4;

endpackage

// File: rtl/xgriscv_mem_arbiter_lat_counter.sv
// Transaction latency counter: counts 1..MEM_LAT while a memory access is in flight.
module arb_lat_counter #(
  parameter  int unsigned MEM_LAT = 2,
  localparam int unsigned CW      = $clog2(MEM_LAT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == CW'(MEM_LAT));

endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and MEM-stage data access,
// with data priority bounded by a starvation guard that forces periodic fetch grants.
module xgriscv_mem_arbiter
  import xgriscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MEM_LAT    = ARB_MEM_LAT,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 if_req_i,
  input  logic [ADDR_SIZE-1:0] if_addr_i,
  input  logic                 flushF_i,
  output logic                 if_ack_o,
  output logic [XLEN-1:0]      if_rdata_o,
  input  logic                 d_req_i,
  input  logic                 d_we_i,
  input  logic [3:0]           d_be_i,
  input  logic [ADDR_SIZE-1:0] d_addr_i,
  input  logic [XLEN-1:0]      d_wdata_i,
  output logic                 d_ack_o,
  output logic [XLEN-1:0]      d_rdata_o,
  output logic                 stallF_o,
  output logic                 stallM_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  input  logic [XLEN-1:0]      mem_rdata_i
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  arb_state_e           state_q, state_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 cancel_q, cancel_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;

  logic [CW-1:0] cnt;
  logic          cnt_done;
  logic          busy, idle, d_win, f_win;
  logic          if_addr_unused;

  assign if_addr_unused = ^if_addr_i[1:0];

  assign busy  = (state_q != ARB_IDLE);
  assign idle  = (state_q == ARB_IDLE);
  assign d_win = idle & d_req_i & (~if_req_i | (starve_q < SW'(STARVE_MAX)));
  assign f_win = idle & ~d_win & if_req_i & ~flushF_i;

  // The grant cycle itself advances the counter so cnt==1 lands on the mem_en cycle.
  arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (busy & cnt_done),
    .en_i    (d_win | f_win | busy),
    .cnt_o   (cnt),
    .done_o  (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cancel_d    = cancel_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_ack_o    = 1'b0;
    d_ack_o     = 1'b0;
    if_rdata_o  = '0;
    d_rdata_o   = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      ARB_IDLE: begin
        cancel_d = 1'b0;
        if (d_win) begin
          state_d = ARB_BUSY_D;
          we_d    = d_we_i;
          be_d    = d_be_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          if (!if_req_i) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (f_win) begin
          state_d  = ARB_BUSY_I;
          we_d     = 1'b0;
          be_d     = 4'hF;
          addr_d   = {if_addr_i[ADDR_SIZE-1:2], 2'b00};
          wdata_d  = '0;
          starve_d = '0;
        end else if (!if_req_i) begin
          starve_d = '0;
        end
      end
      ARB_BUSY_I: begin
        if (cnt_done) begin
          state_d  = ARB_IDLE;
          cancel_d = 1'b0;
        end else if (flushF_i) begin
          cancel_d = 1'b1;
        end
        // A flush in the ack cycle itself also discards the wrong-path instruction.
        if_ack_o = cnt_done & ~cancel_q & ~flushF_i;
      end
      ARB_BUSY_D: begin
        if (cnt_done) begin
          state_d = ARB_IDLE;
        end
        d_ack_o = cnt_done;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (busy) begin
      mem_en_o    = (cnt == CW'(1));
      mem_we_o    = we_q;
      mem_be_o    = be_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
    end
    if (if_ack_o) if_rdata_o = mem_rdata_i;
    if (d_ack_o)  d_rdata_o  = mem_rdata_i;

    stallF_o = rst_ni & if_req_i & ~if_ack_o & ~flushF_i;
    stallM_o = rst_ni & d_req_i & ~d_ack_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      cancel_q <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cancel_q <= cancel_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// Self-checking bench for xgriscv_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model with its own memory image.
module tb_xgriscv_mem_arbiter;

  localparam int L    = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        ifReq = 1'b0, flushF = 1'b0, dReq = 1'b0, dWe = 1'b0;
  logic [31:0] ifAddr = '0, dAddr = '0, dWdata = '0;
  logic [3:0]  dBe = '0;
  logic        ifAck, dAck, stallF, stallM, memEn, memWe;
  logic [31:0] ifRdata, dRdata, memAddr, memWdata, memRdata;
  logic [3:0]  memBe;

  logic [31:0] memArr [256];
  logic [31:0] refMem [256];

  int vecCount = 0;
  int missCount = 0;
  int cyc = 0;

  // Reference model: one outstanding transaction described by its grant cycle.
  bit          mBusy = 0, mIsData = 0, mCancel = 0;
  int          mStart = 0, mStarve = 0;
  logic        mWe = 1'b0;
  logic [3:0]  mBe = '0;
  logic [31:0] mAddr = '0, mWdata = '0;

  logic        obsIfAck, obsDAck;
  logic [31:0] obsIfRdata, obsDRdata;

  always #5 clk = ~clk;

  assign memRdata = memArr[memAddr[9:2]];

  xgriscv_mem_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .if_req_i    (ifReq),
    .if_addr_i   (ifAddr),
    .flushF_i    (flushF),
    .if_ack_o    (ifAck),
    .if_rdata_o  (ifRdata),
    .d_req_i     (dReq),
    .d_we_i      (dWe),
    .d_be_i      (dBe),
    .d_addr_i    (dAddr),
    .d_wdata_i   (dWdata),
    .d_ack_o     (dAck),
    .d_rdata_o   (dRdata),
    .stallF_o    (stallF),
    .stallM_o    (stallM),
    .mem_en_o    (memEn),
    .mem_we_o    (memWe),
    .mem_be_o    (memBe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_rdata_i (memRdata)
  );

  function automatic logic [31:0] patt(input int i);
    if (i == 4) return 32'h0050_0093;
    return (32'h1000_0000 + 32'(i) * 32'h0001_0203) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    vecCount++;
    if (obs !== expVal) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, expVal, cyc);
    end
  endtask

  // Drives one cycle of inputs, checks outputs against the model, then advances the model.
  task automatic applyStimulus(input logic r, input logic ifr, input logic [31:0] ifa, input logic fl,
                               input logic dr, input logic dwe, input logic [3:0] dbe,
                               input logic [31:0] da, input logic [31:0] dwd);
    int   phase;
    bit   dWin, fWin, expMemEn, expIfAck, expDAck;
    logic [31:0] expData;
    @(negedge clk);
    rstN = r; ifReq = ifr; ifAddr = ifa; flushF = fl;
    dReq = dr; dWe = dwe; dBe = dbe; dAddr = da; dWdata = dwd;
    #1;
    cyc++;
    obsIfAck = ifAck; obsDAck = dAck; obsIfRdata = ifRdata; obsDRdata = dRdata;
    if (!r) begin
      checkOutput("rst_ctrl", {26'b0, ifAck, dAck, stallF, stallM, memEn, memWe}, 32'h0);
      checkOutput("rst_ifRdata", ifRdata, 32'h0);
      checkOutput("rst_dRdata", dRdata, 32'h0);
      checkOutput("rst_memAddr", memAddr, 32'h0);
      checkOutput("rst_memWdata", memWdata, 32'h0);
      checkOutput("rst_memBe", 32'(memBe), 32'h0);
      mBusy = 0; mStarve = 0; mCancel = 0;
      return;
    end
    phase    = mBusy ? cyc - mStart : 0;
    expMemEn = mBusy && phase == 1;
    expIfAck = mBusy && phase == L && !mIsData && !mCancel && !fl;
    expDAck  = mBusy && phase == L && mIsData;
    expData  = refMem[mAddr[9:2]];
    checkOutput("memEn", 32'(memEn), 32'(expMemEn));
    if (expMemEn) begin
      checkOutput("memAddr", memAddr, mAddr);
      checkOutput("memWe", 32'(memWe), 32'(mWe));
      checkOutput("memBe", 32'(memBe), 32'(mBe));
      if (mWe) checkOutput("memWdata", memWdata, mWdata);
    end
    checkOutput("ifAck", 32'(ifAck), 32'(expIfAck));
    checkOutput("dAck", 32'(dAck), 32'(expDAck));
    if (expIfAck) checkOutput("ifRdata", ifRdata, expData);
    if (expDAck && !mWe) checkOutput("dRdata", dRdata, expData);
    checkOutput("stallF", 32'(stallF), 32'(ifr && !expIfAck && !fl));
    checkOutput("stallM", 32'(stallM), 32'(dr && !expDAck));

    if (mBusy) begin
      if (expMemEn && mWe)
        for (int b = 0; b < 4; b++)
          if (mBe[b]) refMem[mAddr[9:2]][8*b +: 8] = mWdata[8*b +: 8];
      if (!mIsData && fl) mCancel = 1;
      if (phase == L) mBusy = 0;
    end else begin
      dWin = dr && (!ifr || mStarve < SMAX);
      fWin = !dWin && ifr && !fl;
      if (dWin) begin
        mBusy = 1; mIsData = 1; mStart = cyc; mCancel = 0;
        mWe = dwe; mBe = dbe; mAddr = da; mWdata = dwd;
        mStarve = ifr ? ((mStarve < SMAX) ? mStarve + 1 : SMAX) : 0;
      end else if (fWin) begin
        mBusy = 1; mIsData = 0; mStart = cyc; mCancel = 0;
        mWe = 1'b0; mBe = 4'hF; mAddr = {ifa[31:2], 2'b00}; mWdata = '0;
        mStarve = 0;
      end else if (!ifr) begin
        mStarve = 0;
      end
    end

    // Memory environment: byte-enabled write taken at the coming rising edge.
    if (memEn && memWe)
      for (int b = 0; b < 4; b++)
        if (memBe[b]) memArr[memAddr[9:2]][8*b +: 8] = memWdata[8*b +: 8];
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int tStart, ifAt, dAt, ackAt;
    logic [31:0] ackData;
    int dOffs[$];
    bit ifPend, dPend, ifDone, dDone, rWe, fl;
    logic [31:0] rIfA, rDa, rDwd;
    logic [3:0]  rBe;

    for (int i = 0; i < 256; i++) begin
      memArr[i] = patt(i);
      refMem[i] = patt(i);
    end

    // Reset with random inputs, then release with nothing requested.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), $urandom, $urandom);
    idleCycles(3);

    // Fetch only.
    ackAt = -1; ackData = '0; tStart = 0;
    for (int i = 0; i < 10 && ackAt < 0; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h12, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if (i == 0) tStart = cyc;
      if (obsIfAck) begin ackAt = cyc - tStart; ackData = obsIfRdata; end
    end
    checkOutput("t2_ifAckLatency", ackAt, 2);
    checkOutput("t2_ifRdata", ackData, 32'h0050_0093);
    idleCycles(1);

    // Collision: store wins, fetch follows.
    ifDone = 0; dDone = 0; ifAt = -1; dAt = -1;
    for (int i = 0; i < 20 && !(ifDone && dDone); i++) begin
      applyStimulus(1'b1, !ifDone, 32'h14, 1'b0, !dDone, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
      if (i == 0) tStart = cyc;
      if (obsDAck) begin dDone = 1; dAt = cyc - tStart; end
      if (obsIfAck) begin ifDone = 1; ifAt = cyc - tStart; end
    end
    checkOutput("t3_dAck", dAt, 2);
    checkOutput("t3_ifAck", ifAt, 5);
    idleCycles(1);
    ackData = '0; ackAt = -1;
    for (int i = 0; i < 10 && ackAt < 0; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
      if (obsDAck) begin ackAt = i; ackData = obsDRdata; end
    end
    checkOutput("t3_storeHalf", ackData, (patt(64) & 32'hFFFF_0000) | 32'h0000_BEEF);
    idleCycles(2);

    // Starvation: fetch held while data is re-requested back to back.
    dOffs.delete(); ifAt = -1;
    for (int i = 0; i < 40 && ifAt < 0; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
      if (i == 0) tStart = cyc;
      if (obsDAck) dOffs.push_back(cyc - tStart);
      if (obsIfAck) ifAt = cyc - tStart;
    end
    checkOutput("t4_dAckCount", dOffs.size(), 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t4_dAck%0d", k), (k < dOffs.size()) ? dOffs[k] : -1, 2 + 3 * k);
    checkOutput("t4_ifAck", ifAt, 14);
    dAt = -1;
    for (int i = 0; i < 8 && dAt < 0; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
      if (obsDAck) dAt = cyc - tStart;
    end
    checkOutput("t4_dataResumes", dAt, 17);
    idleCycles(2);

    // Flush of an in-flight fetch, then a redirected fetch.
    ifAt = -1; ackData = '0;
    applyStimulus(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tStart = cyc;
    dAt = 0;
    applyStimulus(1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    if (obsIfAck) dAt++;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    if (obsIfAck) dAt++;
    checkOutput("t5_flushedAcks", dAt, 0);
    for (int i = 0; i < 10 && ifAt < 0; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if (obsIfAck) begin ifAt = cyc - tStart; ackData = obsIfRdata; end
    end
    checkOutput("t5_ifAck", ifAt, 5);
    checkOutput("t5_ifRdata", ackData, patt(16));
    idleCycles(2);

    // Reset in the ack cycle of a load, then retry.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    checkOutput("t6_dAckInReset", 32'(obsDAck), 32'h0);
    dAt = -1; ackData = '0;
    for (int i = 0; i < 10 && dAt < 0; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
      if (i == 0) tStart = cyc;
      if (obsDAck) begin dAt = cyc - tStart; ackData = obsDRdata; end
    end
    checkOutput("t6_retryLatency", dAt, 2);
    checkOutput("t6_retryData", ackData, (patt(64) & 32'hFFFF_0000) | 32'h0000_BEEF);
    idleCycles(1);

    // Random traffic from two protocol-respecting requesters.
    ifPend = 0; dPend = 0; rIfA = '0; rDa = '0; rDwd = '0; rBe = '0; rWe = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ifPend && $urandom_range(0, 2) == 0) begin
        ifPend = 1; rIfA = 32'($urandom_range(0, 63));
      end
      if (!dPend && $urandom_range(0, 2) == 0) begin
        dPend = 1; rWe = 1'($urandom); rBe = 4'($urandom);
        rDa = 32'($urandom_range(0, 63)); rDwd = $urandom;
      end
      fl = ($urandom_range(0, 15) == 0);
      applyStimulus(($urandom_range(0, 399) != 0), ifPend, rIfA, fl, dPend, rWe, rBe, rDa, rDwd);
      if (fl || obsIfAck) ifPend = 0;
      if (obsDAck) dPend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
